// File: rtl/key_move_if.sv
`default_nettype none
// ==========================================================================
// key_move_if : scan-byte input and move-queue output bundle (rev 1.0)
// ==========================================================================
interface key_move_if #(
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             newKey;
  logic [7:0]       keyCode;
  logic             move_ready;
  logic [1:0]       move;
  logic             move_valid;
  logic [CNT_W-1:0] count;
  logic             drop;

  modport master (
    output newKey, keyCode, move_ready,
    input  move, move_valid, count, drop
  );

  modport slave (
    input  newKey, keyCode, move_ready,
    output move, move_valid, count, drop
  );
endinterface
`default_nettype wire

// File: rtl/key_move_queue.sv
`default_nettype none
// ==========================================================================
// key_move_queue : PS/2 E0/F0 prefix tracker, make-code to move decoder and
// move FIFO with duplicate filter. Option: KEY_MOVE_REVERSE_FILTER_EN. rev 1.0
// ==========================================================================
module key_move_queue #(
  parameter int DEPTH   = 4,
  parameter int WASD_EN = 1
) (
  input wire logic  clk,
  input wire logic  reset,
  key_move_if.slave kif
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXT     = 2'd1,
    S_BRK     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [CNT_W-1:0] count_r, count_nxt;
  logic [1:0]       move_r, move_nxt, ref_dir, last_dir, dec_mv, head_nxt;
  logic             valid_r, drop_r;
  logic             byte_dec, ext, dec_hit, dup, rev, full, pop, push;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    byte_dec  = 1'b0;
    ext       = 1'b0;
    if (kif.newKey) begin
      case (state)
        S_IDLE: begin
          if (kif.keyCode == 8'hE0)      state_nxt = S_EXT;
          else if (kif.keyCode == 8'hF0) state_nxt = S_BRK;
          else                           byte_dec  = 1'b1;
        end
        S_EXT: begin
          if (kif.keyCode == 8'hF0)      state_nxt = S_EXT_BRK;
          else if (kif.keyCode == 8'hE0) state_nxt = S_EXT;
          else begin
            byte_dec  = 1'b1;
            ext       = 1'b1;
            state_nxt = S_IDLE;
          end
        end
        default: state_nxt = S_IDLE;   // break target byte is swallowed
      endcase
    end
  end

  always_comb begin
    dec_hit = 1'b0;
    dec_mv  = 2'd0;
    if (byte_dec) begin
      case (kif.keyCode)
        8'h74: begin dec_hit = 1'b1; dec_mv = 2'd0; end
        8'h75: begin dec_hit = 1'b1; dec_mv = 2'd1; end
        8'h6B: begin dec_hit = 1'b1; dec_mv = 2'd2; end
        8'h72: begin dec_hit = 1'b1; dec_mv = 2'd3; end
        default: begin
          if (WASD_EN != 0 && !ext) begin
            case (kif.keyCode)
              8'h23: begin dec_hit = 1'b1; dec_mv = 2'd0; end
              8'h1D: begin dec_hit = 1'b1; dec_mv = 2'd1; end
              8'h1C: begin dec_hit = 1'b1; dec_mv = 2'd2; end
              8'h1B: begin dec_hit = 1'b1; dec_mv = 2'd3; end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  always_comb begin
    last_dir = (count_r != '0) ? mem[PTR_W'(wr_ptr - 1'b1)] : ref_dir;
    dup      = (dec_mv == last_dir);
`ifdef KEY_MOVE_REVERSE_FILTER_EN
    rev      = ((dec_mv ^ last_dir) == 2'b10);
`else
    rev      = 1'b0;
`endif
    full      = (count_r == FULL_CNT);
    pop       = valid_r & kif.move_ready;
    push      = dec_hit & ~dup & ~rev & (~full | pop);
    count_nxt = count_r + CNT_W'(push) - CNT_W'(pop);
    rd_nxt    = pop ? PTR_W'(rd_ptr + 1'b1) : rd_ptr;
    // The slot being written this edge becomes the head when the queue drains to it
    head_nxt  = (push && wr_ptr == rd_nxt) ? dec_mv : mem[rd_nxt];
    move_nxt  = (count_nxt != '0) ? head_nxt : move_r;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 2'd0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
      move_r  <= 2'd0;
      valid_r <= 1'b0;
      drop_r  <= 1'b0;
      ref_dir <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= dec_mv;
        wr_ptr      <= PTR_W'(wr_ptr + 1'b1);
      end
      if (pop) ref_dir <= move_r;
      rd_ptr  <= rd_nxt;
      count_r <= count_nxt;
      move_r  <= move_nxt;
      valid_r <= (count_nxt != '0);
      drop_r  <= dec_hit & ~push;
    end
  end

  assign kif.move       = move_r;
  assign kif.move_valid = valid_r;
  assign kif.count      = count_r;
  assign kif.drop       = drop_r;
endmodule
`default_nettype wire
